memory_game_engine: RTL and testbench
=====================================

Name: memory_game_engine

Overview:
Parametrised single-FSM successor to the per-mode game controllers. It merges classic, reverse and timed modes into one engine that owns all of the following:
- the pattern memory (MAX_LEN entries of SYM_W bits),
- the PRNG,
- the LED playback sequencing,
- per-press input checking with early fail.

Playback is paced by an external tick strobe (clock divider output), so game speed is independent of clk. It sits between the board buttons/debouncer and the LED/score display.

Parameters:
SYM_W, 3, bits per symbol; LED count = 2**SYM_W
MAX_LEN, 25, maximum pattern length; completing a round at this length is a win
ON_TICKS, 4, ticks an LED is lit during playback (>=1)
OFF_TICKS, 2, dark ticks between playback symbols (>=1)
TIME_LIMIT, 40, ticks allowed per input phase in timed mode (>=1)
SEED, 16'hACE1, LFSR reset value (non-zero)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
mode  in  2  0 classic, 1 timed, 2 reverse, 3 treated as classic; sampled only on accepted start
start  in  1  single-cycle pulse; begins a new game
tick  in  1  single-cycle time-base strobe
btn_valid  in  1  single-cycle pulse, one per button press
btn_sym  in  SYM_W  symbol pressed; qualified by btn_valid
led  out  2**SYM_W  one-hot playback LED, else 0
awaiting_input  out  1  high while in INPUT
score  out  $clog2(MAX_LEN+1)  completed rounds
game_over  out  1  high in FAIL
win  out  1  high in WIN

Behaviour:
- Reset (synchronous, rst_n=0 at posedge):
  - state IDLE; led=0, score=0, game_over=0, win=0, awaiting_input=0;
  - len=0, idx=0, pos=0, tick counters 0, LFSR=SEED.
  - Reset mid-game aborts immediately; the pattern memory is not cleared.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1. It advances every clk while out of reset, never gated. A new symbol is LFSR[SYM_W-1:0].
- States IDLE, APPEND, SHOW_ON, SHOW_OFF, INPUT, FAIL, WIN.
- IDLE / FAIL / WIN + start:
  - latch mode; len<=0; score<=0; clear game_over/win; go to APPEND.
  - start in any other state is ignored.
- APPEND (1 cycle): mem[len]<=LFSR[SYM_W-1:0]; len<=len+1; idx<=0; go to SHOW_ON.
- SHOW_ON:
  - led=onehot(mem[idx]), asserted from the first cycle in the state.
  - Count ticks; on the ON_TICKS-th tick go to SHOW_OFF.
- SHOW_OFF:
  - led=0; count ticks; on the OFF_TICKS-th tick:
    - if idx==len-1: go to INPUT, with pos<=0 (classic/timed) or pos<=len-1 (reverse);
    - else: idx++ and go to SHOW_ON.
  - Tick counters clear on every state entry.
- INPUT: awaiting_input=1, led=0. On btn_valid, compare btn_sym with mem[pos]:
  - mismatch: go to FAIL.
  - match, not last (last = pos reached len-1 fwd / 0 rev): step pos.
  - match, last: score<=len; go to WIN if len==MAX_LEN, else APPEND.
- Timed mode only:
  - count ticks in INPUT, from 0 on entry, not reset by correct presses;
  - when the count reaches TIME_LIMIT, go to FAIL;
  - if btn_valid and the limiting tick occur in the same cycle, the press is evaluated first and the timeout is discarded.
- btn_valid outside INPUT is ignored (no queueing).
- Simultaneous btn_valid and start in INPUT: start is ignored.
- FAIL: game_over=1 and score is held until start.
- WIN: win=1 and score=MAX_LEN until start.
- Arithmetic: len, idx, pos are $clog2(MAX_LEN+1) bits, unsigned. pos never wraps: reverse stops at 0, forward at len-1.

Decomposition:
- memory_game_pkg holds:
  - game_state_t enum;
  - game_mode_t enum (MODE_CLASSIC=0, MODE_TIMED=1, MODE_REVERSE=2);
  - lfsr width/taps localparams.
- Sub-module lfsr16, ports (clk, rst_n, seed, value); the engine instantiates it.
- Pattern memory is an inferred register array inside the engine.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles -> all outputs 0, state IDLE. Pulse btn_valid with btn_sym=5 -> no change.
2. Classic, ON_TICKS=2, OFF_TICKS=1, tick every 4 clk, start:
   - exactly one LED lit for 8 clk, then dark, then awaiting_input=1;
   - press the shown symbol -> score=1, replay of 2 symbols whose first matches round 1.
3. Wrong press in round 2, first position -> game_over=1 next cycle, score stays 1, led=0, further btn_valid ignored. Then start -> score=0, game_over=0.
4. Reverse mode, reach len=3 with shown sequence s0,s1,s2:
   - press s2,s1,s0 -> score=3;
   - a new game pressing s0 first (s0!=s2) -> game_over.
5. Timed, TIME_LIMIT=4:
   - no press for 4 ticks in INPUT -> game_over;
   - repeat with a correct final press coincident with the 4th tick -> score increments, no fail.
6. MAX_LEN=4, mode=3:
   - behaves as classic; after 4 correct rounds win=1, score=4;
   - start -> win=0, score=0, new 1-symbol playback.

Source files
------------

// File: rtl/memory_game_pkg.sv
// memory_game_pkg: shared state/mode types and LFSR constants for the memory game engine
package memory_game_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_APPEND, S_SHOW_ON, S_SHOW_OFF, S_INPUT, S_FAIL, S_WIN
    } game_state_t;
    typedef enum logic [1:0] {
        MODE_CLASSIC = 2'd0,
        MODE_TIMED   = 2'd1,
        MODE_REVERSE = 2'd2
    } game_mode_t;
    localparam int LFSR_W = 16;
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;
    function automatic int max2(int a, int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, loads seed while in reset
module lfsr16 import memory_game_pkg::*; (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] value
);
    always_ff @(posedge clk) begin
        if (!rst_n) value <= seed;
        else value <= {^(value & LFSR_TAPS), value[LFSR_W-1:1]};
    end
endmodule

// File: rtl/memory_game_engine.sv
// memory_game_engine: classic/timed/reverse memory game with tick-paced LED playback
module memory_game_engine import memory_game_pkg::*; #(
    parameter int              SYM_W      = 3,
    parameter int              MAX_LEN    = 25,
    parameter int              ON_TICKS   = 4,
    parameter int              OFF_TICKS  = 2,
    parameter int              TIME_LIMIT = 40,
    parameter logic [LFSR_W-1:0] SEED     = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [1:0]                     mode,
    input  logic                           start,
    input  logic                           tick,
    input  logic                           btn_valid,
    input  logic [SYM_W-1:0]               btn_sym,
    output logic [2**SYM_W-1:0]            led,
    output logic                           awaiting_input,
    output logic [$clog2(MAX_LEN+1)-1:0]   score,
    output logic                           game_over,
    output logic                           win
);
    localparam int LEDS = 2**SYM_W;
    localparam int LW   = $clog2(MAX_LEN+1);
    localparam int AW   = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    localparam int TW   = $clog2(max2(max2(ON_TICKS, OFF_TICKS), TIME_LIMIT) + 1);
    localparam logic [TW-1:0]   ON_END  = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0]   OFF_END = TW'(OFF_TICKS - 1);
    localparam logic [TW-1:0]   TL_END  = TW'(TIME_LIMIT - 1);
    localparam logic [TW-1:0]   TL_CAP  = TW'(TIME_LIMIT);
    localparam logic [LW-1:0]   LEN_MAX = LW'(MAX_LEN);
    localparam logic [LEDS-1:0] LED_ONE = {{(LEDS-1){1'b0}}, 1'b1};

    game_state_t        state;
    game_mode_t         gmode;
    logic [LW-1:0]      len, idx, pos;
    logic [TW-1:0]      tcnt;
    logic [SYM_W-1:0]   mem [MAX_LEN];
    logic [LFSR_W-1:0]  lfsr;
    logic [SYM_W-1:0]   new_sym;
    logic [LFSR_W-SYM_W-1:0] unused_lfsr_hi;
    logic               rev, last_pos;

    lfsr16 u_lfsr (.clk(clk), .rst_n(rst_n), .seed(SEED), .value(lfsr));

    assign {unused_lfsr_hi, new_sym} = lfsr;
    assign rev            = gmode == MODE_REVERSE;
    assign last_pos       = rev ? pos == '0 : pos == len - 1'b1;
    assign led            = state == S_SHOW_ON ? LED_ONE << mem[idx[AW-1:0]] : '0;
    assign awaiting_input = state == S_INPUT;
    assign game_over      = state == S_FAIL;
    assign win            = state == S_WIN;

    // Pattern memory survives reset; only APPEND writes it
    always_ff @(posedge clk) begin
        if (rst_n && state == S_APPEND) mem[len[AW-1:0]] <= new_sym;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            gmode <= MODE_CLASSIC;
            len   <= '0;
            idx   <= '0;
            pos   <= '0;
            tcnt  <= '0;
            score <= '0;
        end else begin
            case (state)
                S_IDLE, S_FAIL, S_WIN: if (start) begin
                    gmode <= mode == 2'd3 ? MODE_CLASSIC : game_mode_t'(mode);
                    len   <= '0;
                    score <= '0;
                    state <= S_APPEND;
                end
                S_APPEND: begin
                    len   <= len + 1'b1;
                    idx   <= '0;
                    tcnt  <= '0;
                    state <= S_SHOW_ON;
                end
                S_SHOW_ON: if (tick) begin
                    tcnt  <= tcnt == ON_END ? '0 : tcnt + 1'b1;
                    state <= tcnt == ON_END ? S_SHOW_OFF : S_SHOW_ON;
                end
                S_SHOW_OFF: if (tick) begin
                    if (tcnt != OFF_END) tcnt <= tcnt + 1'b1;
                    else begin
                        tcnt <= '0;
                        if (idx == len - 1'b1) begin
                            pos   <= rev ? len - 1'b1 : '0;
                            state <= S_INPUT;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_SHOW_ON;
                        end
                    end
                end
                S_INPUT: begin
                    if (tick && tcnt != TL_CAP) tcnt <= tcnt + 1'b1;
                    // A press in the same cycle as the limiting tick wins over the timeout
                    if (btn_valid) begin
                        if (btn_sym != mem[pos[AW-1:0]]) state <= S_FAIL;
                        else if (!last_pos) pos <= rev ? pos - 1'b1 : pos + 1'b1;
                        else begin
                            score <= len;
                            state <= len == LEN_MAX ? S_WIN : S_APPEND;
                        end
                    end else if (gmode == MODE_TIMED && tick && tcnt >= TL_END) state <= S_FAIL;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_game_engine.sv
// tb_memory_game_engine: table-driven and randomized games checked against a pattern-queue game model
module tb_memory_game_engine;
    localparam int SYM_W = 3;
    localparam int MAX_LEN = 4;
    localparam int ON_T = 2;
    localparam int OFF_T = 1;
    localparam int TL = 4;
    localparam int LEDS = 1 << SYM_W;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        int mode;
        int wrong_round;
        int wrong_pos;
        int exp_score;
        bit exp_over;
        bit exp_win;
    } vec_t;

    logic clk = 0, rst_n = 0, start = 0, tick = 0, btn_valid = 0;
    logic [1:0] mode = 0;
    logic [SYM_W-1:0] btn_sym = 0;
    logic [LEDS-1:0] led;
    logic awaiting_input, game_over, win;
    logic [LW-1:0] score;

    int n_chk = 0, n_fail = 0;
    logic [15:0] m_lfsr;
    logic [SYM_W-1:0] pattern[$];
    int mmode, mscore;
    int tick_per = 4, tick_cnt = 0;
    bit tick_en = 1;
    vec_t vecs[6];

    memory_game_engine #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T),
                         .TIME_LIMIT(TL), .SEED(SEED)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .start(start), .tick(tick),
        .btn_valid(btn_valid), .btn_sym(btn_sym), .led(led), .awaiting_input(awaiting_input),
        .score(score), .game_over(game_over), .win(win));

    always #5 clk = ~clk;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, shifting right, stepping every clock out of reset
    always @(posedge clk) m_lfsr <= !rst_n ? SEED : {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [LEDS-1:0] oh(logic [SYM_W-1:0] s);
        return LEDS'(1) << s;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        start = 0;
        btn_valid = 0;
        tick_cnt++;
        tick = tick_en && (tick_cnt % tick_per == 0);
    endtask

    task automatic do_start(int m);
        mode = 2'(m);
        start = 1;
        step();
        check("start_score", 32'(score), 0);
        check("start_over", 32'(game_over), 0);
        check("start_win", 32'(win), 0);
        pattern.delete();
        pattern.push_back(m_lfsr[SYM_W-1:0]);
        mmode = m == 3 ? 0 : m;
        mscore = 0;
    endtask

    // Watch one playback: lit runs must spell the pattern, each spanning exactly ON_T ticks, gaps OFF_T ticks
    task automatic playback(bit noise);
        logic [LEDS-1:0] cur = '0;
        int tk = 0, runs = 0, cyc = 0;
        bit last_t = 0, first = 1;
        step();
        check("show_first", 32'(led), 32'(oh(pattern[0])));
        while (!awaiting_input && cyc < 4000) begin
            if (led != cur) begin
                if (cur != 0) check("on_ticks", tk * 2 + int'(last_t), ON_T * 2 + 1);
                else if (!first) check("off_ticks", tk * 2 + int'(last_t), OFF_T * 2 + 1);
                if (led != 0) begin
                    check("play_sym", 32'(led), runs < pattern.size() ? 32'(oh(pattern[runs])) : 32'd0);
                    runs++;
                end
                cur = led;
                tk = 0;
                first = 0;
            end
            tk += int'(tick);
            last_t = tick;
            if (noise && $urandom_range(7, 0) == 0) begin
                btn_valid = 1;
                btn_sym = SYM_W'($urandom);
                start = 1'($urandom_range(1, 0));
            end
            step();
            cyc++;
        end
        check("off_ticks_end", tk * 2 + int'(last_t), OFF_T * 2 + 1);
        check("play_runs", runs, pattern.size());
        check("play_done", 32'(awaiting_input), 1);
        check("input_led", 32'(led), 0);
    endtask

    // res: 0 next round, 1 game over, 2 win
    task automatic input_phase(int wrong_at, int maxgap, output int res);
        int len, k, el, gap;
        bit p, t;
        logic [SYM_W-1:0] e;
        len = pattern.size();
        k = 0;
        el = 0;
        res = -1;
        gap = $urandom_range(maxgap, 0);
        for (int c = 0; c < 400 && res < 0; c++) begin
            p = gap <= 0;
            t = tick;
            e = mmode == 2 ? pattern[len - 1 - k] : pattern[k];
            if (p) begin
                btn_valid = 1;
                btn_sym = k == wrong_at ? e ^ SYM_W'($urandom_range(LEDS - 1, 1)) : e;
                start = 1'($urandom_range(1, 0));
            end
            step();
            if (p && k == wrong_at) res = 1;
            else if (p && k == len - 1) begin
                mscore = len;
                res = len == MAX_LEN ? 2 : 0;
                if (res == 0) pattern.push_back(m_lfsr[SYM_W-1:0]);
            end else if (p) begin
                k++;
                gap = $urandom_range(maxgap, 0);
            end else if (mmode == 1 && t && el + 1 >= TL) res = 1;
            else gap--;
            if (t && el < TL) el++;
        end
        if (res < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL input_bound: no outcome after 400 cycles, expected one");
            res = 1;
        end
        check("in_await", 32'(awaiting_input), 0);
        check("in_over", 32'(game_over), 32'(res == 1));
        check("in_win", 32'(win), 32'(res == 2));
        check("in_score", 32'(score), 32'(mscore));
        check("in_led", 32'(led), 0);
    endtask

    task automatic game(int m, int wr, int wp, int maxgap, bit noise);
        int r = 0, res = 0;
        do_start(m);
        while (res == 0) begin
            playback(noise);
            input_phase(r == wr ? wp : -1, maxgap, res);
            r++;
        end
    endtask

    initial begin
        vecs[0] = '{0, 1, 0, 1, 1, 0};
        vecs[1] = '{2, 3, 0, 3, 1, 0};
        vecs[2] = '{3, -1, 0, 4, 0, 1};
        vecs[3] = '{1, 2, 1, 2, 1, 0};
        vecs[4] = '{2, -1, 0, 4, 0, 1};
        vecs[5] = '{1, -1, 0, 4, 0, 1};

        step();
        step();
        check("rst_led", 32'(led), 0);
        check("rst_await", 32'(awaiting_input), 0);
        check("rst_score", 32'(score), 0);
        check("rst_over", 32'(game_over), 0);
        check("rst_win", 32'(win), 0);
        rst_n = 1;
        btn_valid = 1;
        btn_sym = 5;
        step();
        check("idle_btn_await", 32'(awaiting_input), 0);
        check("idle_btn_led", 32'(led), 0);
        check("idle_btn_over", 32'(game_over), 0);

        foreach (vecs[i]) begin
            tick_per = 4;
            game(vecs[i].mode, vecs[i].wrong_round, vecs[i].wrong_pos, 1, 0);
            check("tbl_score", 32'(score), 32'(vecs[i].exp_score));
            check("tbl_over", 32'(game_over), 32'(vecs[i].exp_over));
            check("tbl_win", 32'(win), 32'(vecs[i].exp_win));
            btn_valid = 1;
            btn_sym = SYM_W'($urandom);
            step();
            check("post_score", 32'(score), 32'(vecs[i].exp_score));
            check("post_over", 32'(game_over), 32'(vecs[i].exp_over));
            check("post_await", 32'(awaiting_input), 0);
        end

        // Timed: silent input phase times out on the TL-th tick
        do_start(1);
        playback(0);
        tick_en = 0;
        tick = 0;
        for (int i = 0; i < TL - 1; i++) begin
            tick = 1;
            step();
            check("tmo_wait", 32'(game_over), 0);
        end
        tick = 1;
        step();
        check("tmo_over", 32'(game_over), 1);
        check("tmo_await", 32'(awaiting_input), 0);
        check("tmo_score", 32'(score), 0);

        // Timed: final correct press coincident with the limiting tick completes the round
        tick_en = 1;
        do_start(1);
        playback(0);
        tick_en = 0;
        tick = 0;
        for (int i = 0; i < TL - 1; i++) begin
            tick = 1;
            step();
        end
        tick = 1;
        btn_valid = 1;
        btn_sym = pattern[0];
        step();
        check("tmo_press_over", 32'(game_over), 0);
        check("tmo_press_score", 32'(score), 1);
        check("tmo_press_await", 32'(awaiting_input), 0);
        pattern.push_back(m_lfsr[SYM_W-1:0]);
        tick_en = 1;
        playback(0);

        // Reset in the middle of a game aborts to idle
        rst_n = 0;
        step();
        check("midrst_await", 32'(awaiting_input), 0);
        check("midrst_score", 32'(score), 0);
        check("midrst_led", 32'(led), 0);
        rst_n = 1;
        step();

        repeat (12) begin
            int m, wr, wp, mg;
            tick_per = $urandom_range(5, 1);
            m = $urandom_range(3, 0);
            wr = $urandom_range(1, 0) == 1 ? int'($urandom_range(MAX_LEN - 1, 0)) : -1;
            wp = $urandom_range(wr < 0 ? 0 : wr, 0);
            mg = $urandom_range(5, 0);
            game(m, wr, wp, mg, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
